// File: rtl/vga_rx_pkg.sv
// rtl/vga_rx_pkg.sv - shared timing defaults, FSM encoding and CRC helpers for the VGA sync receiver
//
// Contents:
//   *_DEF       default 640x480 timing, used as parameter defaults by vga_sync_receiver
//   CNT_MAX     saturation value of the 10-bit line/pixel counters
//   rx_state_t  receiver FSM encoding (SEARCH=0, ACQUIRE=1, LOCKED=2)
//   CRC_POLY    CRC-16-CCITT polynomial
//   CRC_INIT    CRC-16-CCITT start value
//   crc16_byte  one byte of CRC-16-CCITT, MSB first
package vga_rx_pkg;

    localparam int H_TOTAL_DEF          = 800;
    localparam int H_SYNC_TO_ACTIVE_DEF = 144;
    localparam int H_ACTIVE_DEF         = 640;
    localparam int V_TOTAL_DEF          = 525;
    localparam int V_SYNC_TO_ACTIVE_DEF = 35;
    localparam int V_ACTIVE_DEF         = 480;
    localparam int LOCK_FRAMES_DEF      = 2;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

    // The whole byte is folded into the high half first, then shifted out
    // one bit at a time; equivalent to eight serial MSB-first steps.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// rtl/vga_rx_crc16.sv - byte-wide CRC-16-CCITT accumulator
//
// Ports:
//   clk   in   1   clock
//   rst   in   1   asynchronous active-high reset, loads CRC_INIT
//   en    in   1   fold data into the accumulator this cycle
//   clr   in   1   reload CRC_INIT this cycle (wins over en)
//   data  in   8   byte to accumulate
//   crc   out  16  running CRC value
module vga_rx_crc16
    import vga_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_byte(crc, data);
        end
    end

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sink: sync edge tracking, x/y/de recovery, timing check and lock
//
// Optional feature macro: VGA_RX_CRC_EN adds o_frame_crc (CRC-16-CCITT of each locked frame's pixels).
//
// Ports:
//   i_clk         in   1   system clock
//   i_rst         in   1   asynchronous active-high reset
//   i_pix_stb     in   1   pixel strobe; all sampling and state changes are qualified by it
//   i_hs, i_vs    in   1   horizontal / vertical sync, active low
//   i_red/green   in   3   pixel colour
//   i_blue        in   2   pixel colour
//   o_x, o_y      out  10/9  active-area coordinates of the pixel flagged by o_de
//   o_de          out  1   one-cycle pixel valid (active area and locked)
//   o_pix         out  8   {red,green,blue} captured with o_de
//   o_frame_start out  1   one-cycle pulse on a good vs edge while locked
//   o_locked      out  1   high while the FSM is LOCKED
//   o_err         out  1   one-cycle pulse on any line or frame timing mismatch
//   o_line_len    out  10  last measured hs-to-hs distance in strobes (saturating)
//   o_frame_crc   out  16  (VGA_RX_CRC_EN only) CRC of the previous locked frame
module vga_sync_receiver
    import vga_rx_pkg::*;
#(
    parameter int H_TOTAL          = H_TOTAL_DEF,
    parameter int H_SYNC_TO_ACTIVE = H_SYNC_TO_ACTIVE_DEF,
    parameter int H_ACTIVE         = H_ACTIVE_DEF,
    parameter int V_TOTAL          = V_TOTAL_DEF,
    parameter int V_SYNC_TO_ACTIVE = V_SYNC_TO_ACTIVE_DEF,
    parameter int V_ACTIVE         = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES      = LOCK_FRAMES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [2:0]  i_red,
    input  logic [2:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_de,
    output logic [7:0]  o_pix,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err,
    output logic [9:0]  o_line_len
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] o_frame_crc
`endif
);

    localparam logic [9:0] H_TOTAL_C   = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_C   = 10'(V_TOTAL);
    localparam logic [9:0] H_ACT_BEG   = 10'(H_SYNC_TO_ACTIVE);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC_TO_ACTIVE + H_ACTIVE);
    localparam logic [9:0] V_ACT_BEG   = 10'(V_SYNC_TO_ACTIVE);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC_TO_ACTIVE + V_ACTIVE);
    localparam logic [2:0] LOCK_TARGET = 3'(LOCK_FRAMES);

    rx_state_t   state, state_next;
    logic [2:0]  good_cnt, good_next, good_inc;
    logic        err_next, fs_next;

    logic        prev_hs, prev_vs;
    logic        hs_edge, vs_edge;
    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  h_inc, v_inc;
    logic [9:0]  h_pos, v_pos;
    logic        line_err;
    logic        line_bad, frame_good;
    logic        active, de_next;
    logic [7:0]  pix_in;

    assign pix_in = {i_red, i_green, i_blue};

    // Edges only exist on a strobe, so nothing downstream moves between strobes.
    assign hs_edge = i_pix_stb & prev_hs & ~i_hs;
    assign vs_edge = i_pix_stb & prev_vs & ~i_vs;

    assign h_inc = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
    assign v_inc = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 10'd1;

    // Position of the pixel sampled on this strobe (also the next counter values).
    // A vs edge wins over a coincident hs edge: that hs edge starts line 0.
    assign h_pos = hs_edge ? 10'd0 : h_inc;
    assign v_pos = vs_edge ? 10'd0 : (hs_edge ? v_inc : v_cnt);

    // A saturated counter means sync was lost; it never counts as a match.
    assign line_bad   = hs_edge & ((h_cnt == CNT_MAX) | (h_inc != H_TOTAL_C));
    assign frame_good = (v_cnt != CNT_MAX) & (v_inc == V_TOTAL_C) & ~line_err & ~line_bad;

    assign active  = (h_pos >= H_ACT_BEG) & (h_pos < H_ACT_END) &
                     (v_pos >= V_ACT_BEG) & (v_pos < V_ACT_END);
    assign de_next = i_pix_stb & active & (state == ST_LOCKED);

    assign good_inc = good_cnt + 3'd1;

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = 1'b0;
        fs_next    = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_next = ST_ACQUIRE;
                    good_next  = 3'd0;
                end
            end
            ST_ACQUIRE: begin
                if (vs_edge) begin
                    if (frame_good) begin
                        good_next = good_inc;
                        if (good_inc >= LOCK_TARGET) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        err_next  = 1'b1;
                        good_next = 3'd0;
                    end
                end else if (line_bad) begin
                    err_next  = 1'b1;
                    good_next = 3'd0;
                end
            end
            ST_LOCKED: begin
                if (vs_edge) begin
                    if (frame_good) begin
                        fs_next = 1'b1;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_ACQUIRE;
                        good_next  = 3'd0;
                    end
                end else if (line_bad) begin
                    err_next   = 1'b1;
                    state_next = ST_ACQUIRE;
                    good_next  = 3'd0;
                end
            end
            default: begin
                state_next = ST_SEARCH;
                good_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_SEARCH;
            good_cnt      <= 3'd0;
            prev_hs       <= 1'b1;
            prev_vs       <= 1'b1;
            h_cnt         <= 10'd0;
            v_cnt         <= 10'd0;
            line_err      <= 1'b0;
            o_x           <= 10'd0;
            o_y           <= 9'd0;
            o_de          <= 1'b0;
            o_pix         <= 8'd0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_line_len    <= 10'd0;
        end else begin
            state         <= state_next;
            good_cnt      <= good_next;
            o_locked      <= (state_next == ST_LOCKED);
            o_err         <= err_next;
            o_frame_start <= fs_next;
            o_de          <= de_next;
            if (i_pix_stb) begin
                prev_hs <= i_hs;
                prev_vs <= i_vs;
                h_cnt   <= h_pos;
                v_cnt   <= v_pos;
                // Line errors are remembered until the vs edge that judges the frame.
                line_err <= vs_edge ? 1'b0 : (line_err | line_bad);
            end
            if (hs_edge) begin
                o_line_len <= h_inc;
            end
            if (de_next) begin
                o_x   <= h_pos - H_ACT_BEG;
                o_y   <= 9'(v_pos - V_ACT_BEG);
                o_pix <= pix_in;
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_acc;

    vga_rx_crc16 u_crc (
        .clk  (i_clk),
        .rst  (i_rst),
        .en   (de_next),
        .clr  (vs_edge),
        .data (pix_in),
        .crc  (crc_acc)
    );

    // Only frames that were fully received while locked are published.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_crc <= 16'd0;
        end else if (vs_edge && (state == ST_LOCKED)) begin
            o_frame_crc <= crc_acc;
        end
    end
`endif

endmodule
